// File: rtl/gate_reduce_pkg.sv
// gate_reduce_pkg: op and state types plus the two-operand bitwise op (NOR folds as OR, inverted at the output)
package gate_reduce_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {OP_OR = 2'd0, OP_AND = 2'd1, OP_XOR = 2'd2, OP_NOR = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  function automatic logic [MAX_W-1:0] apply_op(op_t op, logic [MAX_W-1:0] a, logic [MAX_W-1:0] b);
    return op == OP_AND ? a & b : op == OP_XOR ? a ^ b : a | b;
  endfunction
endpackage

// File: rtl/gate_reduce_comb.sv
// gate_reduce_comb: combinational reduction of NUM_IN WIDTH-bit channels (in_data, op -> r), WIDTH <= 64
module gate_reduce_comb
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              op,
  output logic [WIDTH-1:0]        r
);
  always_comb begin
    r = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++)
      r = WIDTH'(apply_op(op_t'(op), MAX_W'(r), MAX_W'(in_data[k*WIDTH +: WIDTH])));
  end
endmodule

// File: rtl/gate_reduce_pipe.sv
// gate_reduce_pipe: frame-accumulating OR/AND/XOR/NOR reduction, valid/ready in (in_*) and registered result out (out_data/out_count); GATE_REDUCE_PARITY_EN adds out_parity
module gate_reduce_pipe
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic [1:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count
`ifdef GATE_REDUCE_PARITY_EN
  ,
  output logic                    out_parity
`endif
);
  state_t state, state_n;
  op_t op_q, op_n, cur_op;
  logic [WIDTH-1:0] acc, acc_n, r, res;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic take;
  assign in_ready = state != OUT;
  assign out_valid = state == OUT;
  assign take = in_valid && in_ready;
  assign cur_op = state == IDLE ? op_t'(op) : op_q;
  gate_reduce_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_comb (
    .in_data(in_data),
    .op(cur_op),
    .r(r)
  );
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    op_n = op_q;
    if (state == OUT) state_n = out_ready ? IDLE : OUT;
    else if (take) begin
      op_n = cur_op;
      acc_n = state == IDLE ? r : WIDTH'(apply_op(op_q, MAX_W'(acc), MAX_W'(r)));
      cnt_n = state == IDLE ? CNT_W'(1) : &cnt ? cnt : cnt + 1'b1;
      state_n = in_last ? OUT : ACC;
    end
  end
  assign res = op_n == OP_NOR ? ~acc_n : acc_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      op_q <= OP_OR;
      out_data <= '0;
      out_count <= '0;
`ifdef GATE_REDUCE_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      op_q <= op_n;
      if (take && in_last) begin
        out_data <= res;
        out_count <= cnt_n;
`ifdef GATE_REDUCE_PARITY_EN
        out_parity <= ^res;
`endif
      end
    end
  end
endmodule

// File: tb/tb_gate_reduce_pipe.sv
// tb_gate_reduce_pipe: directed and randomized frames checked against a channel-fold reference model
module tb_gate_reduce_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam int C = 8;
  typedef logic [N*W-1:0] beat_t;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [N*W-1:0] in_data = '0;
  logic [1:0] op = 2'd0;
  logic [W-1:0] out_data;
  logic [C-1:0] out_count;
`ifdef GATE_REDUCE_PARITY_EN
  logic out_parity;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  gate_reduce_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(C)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
`ifdef GATE_REDUCE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );
  function automatic logic [W-1:0] model(input logic [1:0] fop, input beat_t bq[$]);
    logic [W-1:0] v, c;
    v = fop == 2'd1 ? '1 : '0;
    foreach (bq[i]) begin
      for (int k = 0; k < N; k++) begin
        c = W'(bq[i] >> (k * W));
        case (fop)
          2'd1: v = v & c;
          2'd2: v = v ^ c;
          default: v = v | c;
        endcase
      end
    end
    return fop == 2'd3 ? ~v : v;
  endfunction
  function automatic logic [C-1:0] model_cnt(input int n);
    return n > 255 ? 8'hFF : C'(n);
  endfunction
  task automatic drive_frame(input logic [1:0] fop, input beat_t bq[$], input bit gaps);
    for (int i = 0; i < bq.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1;
      in_data = bq[i];
      in_last = i == bq.size() - 1;
      op = i == 0 ? fop : ~fop;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic release_out;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_count !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", out_count); end
  endtask
  task automatic test_or_single;
    beat_t q[$];
    q.push_back(32'h08040201);
    drive_frame(2'd0, q, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL or_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h0F) begin errors++; $display("FAIL or_data got=%h exp=0f", out_data); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL or_count got=%0d exp=1", out_count); end
    release_out;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_drop got=%b exp=0", out_valid); end
  endtask
  task automatic test_and_multi;
    beat_t q[$];
    q.push_back(32'hFFF0FEF1);
    q.push_back(32'hF030FFFF);
    drive_frame(2'd1, q, 0);
    checks++; if (out_data !== 8'h30) begin errors++; $display("FAIL and_data got=%h exp=30", out_data); end
    checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL and_count got=%0d exp=2", out_count); end
    release_out;
  endtask
  task automatic test_xor_nor;
    beat_t q[$];
    q.push_back(32'hAA550F00);
    drive_frame(2'd2, q, 0);
    checks++; if (out_data !== 8'hF0) begin errors++; $display("FAIL xor_data got=%h exp=f0", out_data); end
    release_out;
    q = {};
    q.push_back(32'h00000001);
    drive_frame(2'd3, q, 0);
    checks++; if (out_data !== 8'hFE) begin errors++; $display("FAIL nor_data got=%h exp=fe", out_data); end
    release_out;
    q = {};
    q.push_back(32'h00000000);
    drive_frame(2'd3, q, 0);
    checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL nor_zero got=%h exp=ff", out_data); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL nor_count got=%0d exp=1", out_count); end
    release_out;
  endtask
  task automatic test_backpressure;
    beat_t q[$];
    q.push_back(32'h00000011);
    drive_frame(2'd0, q, 0);
    for (int j = 0; j < 3; j++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", j, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", j, in_ready); end
      checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=11", j, out_data); end
      checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL bp_count cyc=%0d got=%0d exp=1", j, out_count); end
      in_valid = 1;
      in_data = 32'hFFFFFFFF;
      in_last = 1;
      op = 2'd0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL bp_hold got=%h exp=11", out_data); end
    in_valid = 0;
    in_last = 0;
    release_out;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL bp_keep got=%h exp=11", out_data); end
  endtask
  task automatic test_reset_midframe;
    beat_t q[$];
    @(negedge clk);
    in_valid = 1;
    in_data = 32'hFFFFFFFF;
    in_last = 0;
    op = 2'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
    q.push_back(32'h01000000);
    drive_frame(2'd0, q, 0);
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL mid_data got=%h exp=01", out_data); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL mid_count got=%0d exp=1", out_count); end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstout_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstout_data got=%h exp=00", out_data); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rstout_count got=%0d exp=0", out_count); end
  endtask
  task automatic test_saturation;
    beat_t q[$];
    for (int i = 0; i < 300; i++) q.push_back(i == 5 ? 32'h00000007 : 32'h0);
    drive_frame(2'd0, q, 0);
    checks++; if (out_data !== 8'h07) begin errors++; $display("FAIL sat_data got=%h exp=07", out_data); end
    checks++; if (out_count !== 8'hFF) begin errors++; $display("FAIL sat_count got=%h exp=ff", out_count); end
`ifdef GATE_REDUCE_PARITY_EN
    checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL sat_parity got=%b exp=1", out_parity); end
`endif
    release_out;
  endtask
  task automatic test_random;
    beat_t q[$];
    logic [1:0] fop;
    logic [W-1:0] exp_d;
    logic [C-1:0] exp_c;
    for (int f = 0; f < 30; f++) begin
      q = {};
      fop = 2'($urandom);
      for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back($urandom);
      exp_d = model(fop, q);
      exp_c = model_cnt(q.size());
      drive_frame(fop, q, 1);
      for (int j = 0; j <= $urandom_range(0, 2); j++) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid f=%0d got=%b exp=1", f, out_valid); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rnd_data f=%0d op=%0d got=%h exp=%h", f, fop, out_data, exp_d); end
        checks++; if (out_count !== exp_c) begin errors++; $display("FAIL rnd_count f=%0d got=%0d exp=%0d", f, out_count, exp_c); end
`ifdef GATE_REDUCE_PARITY_EN
        checks++; if (out_parity !== ^exp_d) begin errors++; $display("FAIL rnd_parity f=%0d got=%b exp=%b", f, out_parity, ^exp_d); end
`endif
        @(posedge clk);
        @(negedge clk);
      end
      release_out;
    end
  endtask
  initial begin
    test_reset;
    test_or_single;
    test_and_multi;
    test_xor_nor;
    test_backpressure;
    test_reset_midframe;
    test_saturation;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
